// File: rtl/simt_reconv_stack_pkg.sv
// Shared GPU types for the SIMT reconvergence stack.
// Entry layout is {reconvergence_pc, active_mask, taken_mask}.
package pkg_opengpu;

  localparam int ADDR_WIDTH       = 32;
  localparam int WARP_SIZE        = 32;
  localparam int WARP_ID_W        = 3;
  localparam int SIMT_STACK_DEPTH = 8;
  localparam int SIMT_DEPTH_W     =
    $clog2(SIMT_STACK_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] reconvergence_pc;
    logic [WARP_SIZE-1:0]  active_mask;
    logic [WARP_SIZE-1:0]  taken_mask;
  } simt_stack_entry_t;

endpackage

// File: rtl/simt_reconv_stack_if.sv
// Execute-stage <-> reconvergence stack push/pop/query bundle.
// master = simt_execute_stage side, slave = stack.
interface simt_reconv_stack_if;
  import pkg_opengpu::*;

  logic [WARP_ID_W-1:0]    warp_id;
  logic [ADDR_WIDTH-1:0]   query_pc;
  logic                    stack_push;
  logic                    stack_pop;
  simt_stack_entry_t       stack_push_entry;
  simt_stack_entry_t       stack_top_entry;
  logic                    stack_at_reconvergence;
  logic                    stack_empty;
  logic [SIMT_DEPTH_W-1:0] stack_depth;

  modport master (
    output warp_id,
    output query_pc,
    output stack_push,
    output stack_pop,
    output stack_push_entry,
    input  stack_top_entry,
    input  stack_at_reconvergence,
    input  stack_empty,
    input  stack_depth
  );

  modport slave (
    input  warp_id,
    input  query_pc,
    input  stack_push,
    input  stack_pop,
    input  stack_push_entry,
    output stack_top_entry,
    output stack_at_reconvergence,
    output stack_empty,
    output stack_depth
  );

endinterface

// File: rtl/simt_reconv_stack.sv
// Per-warp SIMT reconvergence stack (one flop stack per warp).
// SIMT_STACK_STATS_EN adds high-water marks and a push counter.
module simt_reconv_stack
  import pkg_opengpu::*;
#(
  parameter int NUM_WARPS   = 8,
  parameter int STACK_DEPTH = SIMT_STACK_DEPTH,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int SW =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  simt_reconv_stack_if.slave   ss,
  input  logic                 clear_valid,
  input  logic [WARP_ID_W-1:0] clear_warp_id,
  output logic [NUM_WARPS-1:0] overflow_err,
  output logic [NUM_WARPS-1:0] underflow_err
`ifdef SIMT_STACK_STATS_EN
  ,
  output logic [DW-1:0]        max_depth_seen [NUM_WARPS],
  output logic [31:0]          div_count
`endif
);

  simt_stack_entry_t mem_q [NUM_WARPS][STACK_DEPTH];
  simt_stack_entry_t mem_d [NUM_WARPS][STACK_DEPTH];

  logic [DW-1:0] depth_q [NUM_WARPS];
  logic [DW-1:0] depth_d [NUM_WARPS];

  logic [NUM_WARPS-1:0] ovf_q, ovf_d;
  logic [NUM_WARPS-1:0] unf_q, unf_d;

  logic [DW-1:0]     cur_d;
  logic [DW-1:0]     cur_dm1;
  logic [SW-1:0]     wr_slot;
  logic [SW-1:0]     top_slot;
  logic              cur_empty;
  logic              cur_full;
  logic              blocked;
  simt_stack_entry_t top_ent;

  always_comb begin
    cur_d     = depth_q[ss.warp_id];
    cur_dm1   = cur_d - DW'(1);
    wr_slot   = cur_d[SW-1:0];
    top_slot  = cur_dm1[SW-1:0];
    cur_empty = (cur_d == '0);
    cur_full  = (cur_d == DW'(STACK_DEPTH));
    blocked   = clear_valid &&
                (clear_warp_id == ss.warp_id);
    top_ent   = mem_q[ss.warp_id][top_slot];
  end

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!blocked) begin
      unique case (1'b1)
        ss.stack_push && ss.stack_pop: begin
          // Replace-top; on an empty stack it is a plain push
          if (cur_empty) begin
            mem_d[ss.warp_id][0] = ss.stack_push_entry;
            depth_d[ss.warp_id]  = DW'(1);
          end else begin
            mem_d[ss.warp_id][top_slot] =
              ss.stack_push_entry;
          end
        end
        ss.stack_push && !ss.stack_pop: begin
          if (cur_full) begin
            ovf_d[ss.warp_id] = 1'b1;
          end else begin
            mem_d[ss.warp_id][wr_slot] =
              ss.stack_push_entry;
            depth_d[ss.warp_id] = cur_d + DW'(1);
          end
        end
        ss.stack_pop && !ss.stack_push: begin
          if (cur_empty) begin
            unf_d[ss.warp_id] = 1'b1;
          end else begin
            depth_d[ss.warp_id] = cur_dm1;
          end
        end
        default: ;
      endcase
    end
    if (clear_valid) begin
      depth_d[clear_warp_id] = '0;
      ovf_d[clear_warp_id]   = 1'b0;
      unf_d[clear_warp_id]   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '{default: '0};
      ovf_q   <= '0;
      unf_q   <= '0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ss.stack_empty = cur_empty;
  assign ss.stack_depth = SIMT_DEPTH_W'(cur_d);
  assign ss.stack_top_entry =
    cur_empty ? '0 : top_ent;
  assign ss.stack_at_reconvergence =
    !cur_empty &&
    (ss.query_pc == top_ent.reconvergence_pc);

  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

`ifdef SIMT_STACK_STATS_EN
  logic [DW-1:0] max_q [NUM_WARPS];
  logic [DW-1:0] max_d [NUM_WARPS];
  logic [31:0]   div_q, div_d;
  logic          acc_push;

  always_comb begin
    acc_push = !blocked && ss.stack_push &&
               (ss.stack_pop || !cur_full);
    for (int i = 0; i < NUM_WARPS; i++) begin
      max_d[i] = (depth_d[i] > max_q[i]) ?
                 depth_d[i] : max_q[i];
    end
    if (clear_valid) begin
      max_d[clear_warp_id] = '0;
    end
    div_d = div_q;
    if (acc_push && (div_q != '1)) begin
      div_d = div_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '{default: '0};
      div_q <= '0;
    end else begin
      max_q <= max_d;
      div_q <= div_d;
    end
  end

  assign max_depth_seen = max_q;
  assign div_count      = div_q;
`endif

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Directed scoreboard bench for simt_reconv_stack.
// Expectations are queued per step and checked after the edge.
module tb_simt_reconv_stack;
  import pkg_opengpu::*;

  typedef struct {
    string             tag;
    logic [3:0]        depth;
    simt_stack_entry_t top;
    logic              rc;
    logic [7:0]        ovf;
    logic [7:0]        unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clear_valid;
  logic [WARP_ID_W-1:0] clear_warp_id;
  logic [7:0] overflow_err;
  logic [7:0] underflow_err;
`ifdef SIMT_STACK_STATS_EN
  logic [SIMT_DEPTH_W-1:0] max_seen [8];
  logic [31:0] div_count;
`endif

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  simt_reconv_stack_if sif ();

  simt_reconv_stack #(
    .NUM_WARPS   (8),
    .STACK_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ss            (sif.slave),
    .clear_valid   (clear_valid),
    .clear_warp_id (clear_warp_id),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
`ifdef SIMT_STACK_STATS_EN
    ,
    .max_depth_seen (max_seen),
    .div_count      (div_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic simt_stack_entry_t mk(
    input logic [31:0] pc,
    input logic [31:0] am,
    input logic [31:0] tm
  );
    simt_stack_entry_t e;
    e.reconvergence_pc = pc;
    e.active_mask      = am;
    e.taken_mask       = tm;
    return e;
  endfunction

  function automatic simt_stack_entry_t w3e(input int i);
    return mk(32'h300 + 32'(4 * i),
              32'h1 << i, ~(32'h1 << i));
  endfunction

  function automatic simt_stack_entry_t w2e(input int i);
    return mk(32'h500 + 32'(4 * i),
              32'hA5A5_0000 | 32'(i), 32'h0000_5A5A);
  endfunction

  task automatic chk(
    input string tag,
    input logic [95:0] obs,
    input logic [95:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underrun", 96'd0, 96'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_depth"},
        96'(sif.stack_depth), 96'(e.depth));
    chk({e.tag, "_empty"},
        96'(sif.stack_empty), 96'(e.depth == 4'd0));
    chk({e.tag, "_top"},
        sif.stack_top_entry, e.top);
    chk({e.tag, "_rc"},
        96'(sif.stack_at_reconvergence), 96'(e.rc));
    chk({e.tag, "_ovf"},
        96'(overflow_err), 96'(e.ovf));
    chk({e.tag, "_unf"},
        96'(underflow_err), 96'(e.unf));
  endtask

  task automatic step(
    input string             tag,
    input logic [2:0]        w,
    input logic              psh,
    input logic              pp,
    input simt_stack_entry_t ent,
    input logic              clr,
    input logic [2:0]        cw,
    input logic [31:0]       qpc,
    input logic [3:0]        ed,
    input simt_stack_entry_t et,
    input logic              erc,
    input logic [7:0]        eo,
    input logic [7:0]        eu
  );
    exp_t e;
    sif.warp_id          = w;
    sif.stack_push       = psh;
    sif.stack_pop        = pp;
    sif.stack_push_entry = ent;
    sif.query_pc         = qpc;
    clear_valid          = clr;
    clear_warp_id        = cw;
    e = '{tag, ed, et, erc, eo, eu};
    sb.push_back(e);
    @(posedge clk);
    #1;
    sif.stack_push = 1'b0;
    sif.stack_pop  = 1'b0;
    clear_valid    = 1'b0;
    check_out();
  endtask

  task automatic look(
    input string             tag,
    input logic [2:0]        w,
    input logic [31:0]       qpc,
    input logic [3:0]        ed,
    input simt_stack_entry_t et,
    input logic              erc,
    input logic [7:0]        eo,
    input logic [7:0]        eu
  );
    exp_t e;
    sif.warp_id  = w;
    sif.query_pc = qpc;
    e = '{tag, ed, et, erc, eo, eu};
    sb.push_back(e);
    #1;
    check_out();
  endtask

  simt_stack_entry_t z, e1, e4, e6, ea, eb, ec;

  initial begin
    z  = '0;
    e1 = mk(32'h104, 32'hFFFF_FFFF, 32'h0000_FFFF);
    e4 = mk(32'h400, 32'h1, 32'h1);
    e6 = mk(32'h600, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    ea = mk(32'h700, 32'h3, 32'h1);
    eb = mk(32'h0A0, 32'hC, 32'h4);
    ec = mk(32'h704, 32'h30, 32'h10);

    rst                  = 1'b1;
    clear_valid          = 1'b0;
    clear_warp_id        = '0;
    sif.warp_id          = '0;
    sif.query_pc         = '0;
    sif.stack_push       = 1'b0;
    sif.stack_pop        = 1'b0;
    sif.stack_push_entry = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    look("rst_w0", 0, 32'h0, 0, z, 0, 8'h00, 8'h00);

    // 1: single push and reconvergence query
    step("w0_push", 0, 1, 0, e1, 0, 0, 32'h104,
         1, e1, 1, 8'h00, 8'h00);
    look("w0_q100", 0, 32'h100, 1, e1, 0, 8'h00, 8'h00);

    // 2: fill warp 3 then overflow
    for (int i = 0; i < 8; i++) begin
      step($sformatf("w3_push%0d", i), 3, 1, 0, w3e(i),
           0, 0, 32'h0, 4'(i + 1), w3e(i), 0,
           8'h00, 8'h00);
    end
    step("w3_ovf", 3, 1, 0, mk(32'h3FC, 0, 0), 0, 0,
         32'h0, 8, w3e(7), 0, 8'h08, 8'h00);

    // 3: pop on empty warp 5
    step("w5_unf", 5, 0, 1, z, 0, 0, 32'h0,
         0, z, 0, 8'h08, 8'h20);

    // 4: replace-top on warp 1
    step("w1_p0", 1, 1, 0, mk(32'h110, 1, 0), 0, 0,
         32'h0, 1, mk(32'h110, 1, 0), 0, 8'h08, 8'h20);
    step("w1_p1", 1, 1, 0, mk(32'h120, 2, 0), 0, 0,
         32'h0, 2, mk(32'h120, 2, 0), 0, 8'h08, 8'h20);
    step("w1_repl", 1, 1, 1, mk(32'h200, 3, 1), 0, 0,
         32'h200, 2, mk(32'h200, 3, 1), 1, 8'h08, 8'h20);
    step("w1_pop", 1, 0, 1, z, 0, 0, 32'h0,
         1, mk(32'h110, 1, 0), 0, 8'h08, 8'h20);

    // 5: clear overriding a same-warp push
    for (int i = 0; i < 8; i++) begin
      step($sformatf("w2_push%0d", i), 2, 1, 0, w2e(i),
           0, 0, 32'h0, 4'(i + 1), w2e(i), 0,
           8'h08, 8'h20);
    end
    step("w2_ovf", 2, 1, 0, w2e(9), 0, 0, 32'h0,
         8, w2e(7), 0, 8'h0C, 8'h20);
    for (int k = 1; k <= 5; k++) begin
      step($sformatf("w2_pop%0d", k), 2, 0, 1, z, 0, 0,
           32'h0, 4'(8 - k), w2e(7 - k), 0,
           8'h0C, 8'h20);
    end
    step("w2_clr_push", 2, 1, 0, w2e(11), 1, 2, 32'h0,
         0, z, 0, 8'h08, 8'h20);
    step("w4_push_clr3", 4, 1, 0, e4, 1, 3, 32'h0,
         1, e4, 0, 8'h00, 8'h20);
    look("w3_after_clr", 3, 32'h0, 0, z, 0,
         8'h00, 8'h20);
    step("w6_pp_empty", 6, 1, 1, e6, 0, 0, 32'h600,
         1, e6, 1, 8'h00, 8'h20);
    step("w5_clr", 5, 0, 0, z, 1, 5, 32'h0,
         0, z, 0, 8'h00, 8'h00);

    // 6: interleaved warps 0 and 7, then reset
    step("w7_pa", 7, 1, 0, ea, 0, 0, 32'h0,
         1, ea, 0, 8'h00, 8'h00);
    step("w0_pb", 0, 1, 0, eb, 0, 0, 32'h0,
         2, eb, 0, 8'h00, 8'h00);
    step("w7_pop", 7, 0, 1, z, 0, 0, 32'h0,
         0, z, 0, 8'h00, 8'h00);
    step("w7_pc", 7, 1, 0, ec, 0, 0, 32'h0,
         1, ec, 0, 8'h00, 8'h00);
    step("w0_pop", 0, 0, 1, z, 0, 0, 32'h104,
         1, e1, 1, 8'h00, 8'h00);
    look("w7_look", 7, 32'h704, 1, ec, 1, 8'h00, 8'h00);
    step("w7_pop2", 7, 0, 1, z, 0, 0, 32'h0,
         0, z, 0, 8'h00, 8'h00);
    step("w7_unf", 7, 0, 1, z, 0, 0, 32'h0,
         0, z, 0, 8'h00, 8'h80);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    look("rst2_w0", 0, 32'h104, 0, z, 0, 8'h00, 8'h00);
    look("rst2_w1", 1, 32'h0, 0, z, 0, 8'h00, 8'h00);
    look("rst2_w4", 4, 32'h0, 0, z, 0, 8'h00, 8'h00);
    look("rst2_w6", 6, 32'h0, 0, z, 0, 8'h00, 8'h00);

    chk("sb_drained", 96'(sb.size()), 96'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
